// File: rtl/pipeline_stall_controller.sv
// Pipeline hazard/stall controller: load-use interlock, branch flush, memory wait,
// multi-cycle MULT/DIV HI/LO interlock and halt with drain of an in-flight multiply/divide.
module pipeline_stall_controller #(
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_wait,
  input  logic        load_use_hazard,
  input  logic        branch_taken_decode,
  input  logic        muldiv_start_execute,
  input  logic        muldiv_is_div,
  input  logic        using_HI_LO_decode,
  input  logic        HALT_execute,
  output logic        stall_fetch,
  output logic        stall_decode,
  output logic        stall_execute,
  output logic        clear_fetch_decode,
  output logic        clear_decode_execute,
  output logic        muldiv_busy,
  output logic        halted,
  output logic [31:0] stall_cycle_count
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StMuldiv = 2'd1,
    StDrain  = 2'd2,
    StHalted = 2'd3
  } state_e;

  localparam logic [5:0] MultLoad = 6'(MULT_CYCLES - 1);
  localparam logic [5:0] DivLoad  = 6'(DIV_CYCLES - 1);

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] count_q;
  logic        halt_req;
  logic        cnt_done;

  // A halt only takes effect once memory has released the pipeline.
  assign halt_req = HALT_execute & ~memory_wait;
  assign cnt_done = (cnt_q == 6'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (halt_req) begin
          state_d = StHalted;
        end else if (muldiv_start_execute && !memory_wait) begin
          state_d = StMuldiv;
          cnt_d   = muldiv_is_div ? DivLoad : MultLoad;
        end
      end
      StMuldiv: begin
        // Counting is independent of memory_wait; new starts are ignored.
        if (cnt_done) begin
          state_d = halt_req ? StHalted : StIdle;
        end else begin
          cnt_d = cnt_q - 6'd1;
          if (halt_req) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (cnt_done) begin
          state_d = StHalted;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      StHalted: begin
        state_d = StHalted;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 6'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    stall_fetch          = 1'b0;
    stall_decode         = 1'b0;
    stall_execute        = 1'b0;
    clear_fetch_decode   = 1'b0;
    clear_decode_execute = 1'b0;
    muldiv_busy          = (state_q == StMuldiv) || (state_q == StDrain);
    if (!reset) begin
      // Flush both front-end registers while held in reset.
      clear_fetch_decode   = 1'b1;
      clear_decode_execute = 1'b1;
      muldiv_busy          = 1'b0;
    end else if ((state_q == StHalted) || (state_q == StDrain)) begin
      stall_fetch   = 1'b1;
      stall_decode  = 1'b1;
      stall_execute = 1'b1;
    end else if (memory_wait) begin
      stall_fetch   = 1'b1;
      stall_decode  = 1'b1;
      stall_execute = 1'b1;
    end else if ((state_q == StMuldiv) && using_HI_LO_decode) begin
      stall_fetch          = 1'b1;
      stall_decode         = 1'b1;
      clear_decode_execute = 1'b1;
    end else if (load_use_hazard) begin
      stall_fetch          = 1'b1;
      stall_decode         = 1'b1;
      clear_decode_execute = 1'b1;
    end else if (branch_taken_decode) begin
      clear_fetch_decode = 1'b1;
    end
  end

  assign halted = (state_q == StHalted);

  // Saturating stall counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= 32'd0;
    end else if (stall_fetch && (count_q != 32'hFFFF_FFFF)) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign stall_cycle_count = count_q;

endmodule
